seg7_word_capture: RTL and testbench
====================================

SEG7_WORD_CAPTURE -- requirements
Module: seg7_word_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive identical samples needed before a digit is captured (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 en  input  1  SHALL enable capture; low holds the block idle.
REQ-005 seg_in  input  7  SHALL carry the active-low segment pattern; bit0=a … bit6=g, matching the team's SevenSeg encoder.
REQ-006 dig_sel  input  8  SHALL carry the one-hot, active-high digit strobe; bit i selects nibble i (bits 4i+3:4i).
REQ-007 word_out  output  32  SHALL hold the last fully reassembled word.
REQ-008 word_valid  output  1  SHALL pulse high for one cycle when word_out is updated.
REQ-009 err  output  1  SHALL pulse high for one cycle when a stable but undecodable pattern is captured.
REQ-010 digit_mask  output  8  SHALL show which digits of the current frame have been captured.

Function
REQ-011 Inputs seg_in/dig_sel SHALL be registered into a sample register every cycle.
REQ-012 The decode table SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit). Every other pattern SHALL be invalid.
REQ-013 The FSM SHALL have exactly three states: IDLE, TRACK and HOLD.
REQ-014 IDLE: entered on reset or whenever en=0. The stability counter and digit_mask SHALL be cleared. The FSM SHALL move to TRACK when en=1.
REQ-015 TRACK: the counter SHALL increment on each edge where the incoming pair equals the sample register and the sampled dig_sel is one-hot. Otherwise the counter SHALL clear.
REQ-016 In TRACK, the capture SHALL occur on the edge where the counter reaches STABLE_CYCLES, and the FSM SHALL go to HOLD. With inputs held steady, the capture edge is STABLE_CYCLES+1 edges after the inputs first appear.
REQ-017 Capture of a valid glyph SHALL write its nibble into a shadow word at position i and set digit_mask[i].
REQ-018 Capture of an invalid glyph SHALL assert err for one cycle, clear digit_mask, and leave word_out unchanged.
REQ-019 When a valid capture makes digit_mask all ones, then on that same edge:
  - word_out SHALL load the shadow word, including the new nibble;
  - word_valid SHALL pulse;
  - digit_mask SHALL clear to 0.
REQ-020 Recapturing an already-set digit before the frame completes SHALL overwrite that nibble; digit_mask is unchanged.
REQ-021 HOLD: no further capture. The FSM SHALL return to TRACK, counter cleared, on the first edge where the incoming seg_in or dig_sel differs from the sample.
REQ-022 A dig_sel that is zero or has more than one bit set SHALL never be captured and SHALL hold the counter at 0.
REQ-023 The counter SHALL saturate and never wrap.
REQ-024 en falling mid-frame SHALL discard the partial frame; word_out SHALL be retained.

Reset
REQ-025 On rst_n low, the block SHALL immediately (asynchronously) enter:
  - FSM=IDLE, counter=0, sample register=0x7F/0x00;
  - shadow word=0, word_out=0x00000000;
  - word_valid=0, err=0, digit_mask=0x00.
REQ-026 Reset deassertion mid-scan SHALL restart capture from an empty frame.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the 16-entry glyph table and a SEG_BLANK=0x7F constant; the encoder and this decoder SHALL use the same package.
REQ-028 The glyph-to-nibble decode SHALL be one combinational sub-module, seg7_glyph_decode, with ports pattern[6:0], nibble[3:0] and valid.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - Scan the encoded word 0x1234ABCD, digits 0..7, 6 cycles each, en=1 -> one word_valid pulse, word_out=0x1234ABCD, err never high.
  - Dwell each digit only 4 cycles (STABLE_CYCLES=4) -> no capture, digit_mask stays 0x00, no word_valid.
  - Pattern 0x7F on digit 3 for 6 cycles mid-frame -> err pulses once, digit_mask clears to 0x00, word_out unchanged, then a clean rescan gives the correct word.
  - dig_sel=0x03 held for 10 cycles -> no capture, no err, digit_mask unchanged.
  - rst_n low for 1 cycle after 5 digits captured -> all outputs at reset values; a following full scan of 0xDEADBEEF gives word_out=0xDEADBEEF.
  - Digit 2 scanned twice ('5' then 'A') before the frame completes -> final word_out has nibble 2 = 0xA.

Source files
------------

// File: rtl/seg7_word_capture_pkg.sv
// Shared seven-segment definitions: capture FSM states, glyph table and blank pattern.
// The SevenSeg encoder and the word-capture decoder both import this package.
package seg7_word_capture_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } cap_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low patterns, bit0=a .. bit6=g; entry k is the glyph for nibble k.
   localparam logic [15:0][6:0] GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble lookup; valid is low for any pattern not in the table.
module seg7_glyph_decode
   import seg7_word_capture_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       valid
);

   always_comb begin
      nibble = 4'd0;
      valid  = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (pattern == GLYPHS[k]) begin
            nibble = 4'(k);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_word_capture.sv
// Reassembles a 32-bit word from a multiplexed seven-segment scan by capturing each
// digit once it has been stable for STABLE_CYCLES samples.
//
// state | meaning
// IDLE  | disabled or just reset; counter and frame mask held clear
// TRACK | counting consecutive identical one-hot samples toward a capture
// HOLD  | digit captured; wait for the scan to move before tracking again
module seg7_word_capture
   import seg7_word_capture_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [6:0]  seg_in,
   input  logic [7:0]  dig_sel,
   output logic [31:0] word_out,
   output logic        word_valid,
   output logic        err,
   output logic [7:0]  digit_mask
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   cap_state_e  state_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [6:0]  seg_q;
   logic [7:0]  sel_q;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] word_q;
   logic        valid_q, err_q;
   logic [7:0]  mask_q, mask_d;
   logic        pair_same, sel_onehot;
   logic [3:0]  glyph_nibble;
   logic        glyph_valid;

   seg7_glyph_decode u_decode (
      .pattern (seg_q),
      .nibble  (glyph_nibble),
      .valid   (glyph_valid)
   );

   assign pair_same  = (seg_in == seg_q) && (dig_sel == sel_q);
   assign sel_onehot = is_onehot8(sel_q);
   assign cnt_d      = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
   assign mask_d     = mask_q | sel_q;

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < 8; i++) begin
         if (sel_q[i]) shadow_d[4*i +: 4] = glyph_nibble;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         seg_q    <= SEG_BLANK;
         sel_q    <= 8'h00;
         shadow_q <= 32'h0;
         word_q   <= 32'h0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         mask_q   <= 8'h00;
      end else begin
         seg_q   <= seg_in;
         sel_q   <= dig_sel;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (!en) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mask_q  <= 8'h00;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= TRACK;
                  cnt_q   <= 4'd0;
                  mask_q  <= 8'h00;
               end
               TRACK: begin
                  if (pair_same && sel_onehot) begin
                     cnt_q <= cnt_d;
                     if (cnt_d == STABLE) begin
                        state_q <= HOLD;
                        if (glyph_valid) begin
                           shadow_q <= shadow_d;
                           // Completing the frame publishes the word including this nibble.
                           if (mask_d == 8'hFF) begin
                              word_q  <= shadow_d;
                              valid_q <= 1'b1;
                              mask_q  <= 8'h00;
                           end else begin
                              mask_q <= mask_d;
                           end
                        end else begin
                           err_q  <= 1'b1;
                           mask_q <= 8'h00;
                        end
                     end
                  end else begin
                     cnt_q <= 4'd0;
                  end
               end
               HOLD: begin
                  if (!pair_same) begin
                     state_q <= TRACK;
                     cnt_q   <= 4'd0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign err        = err_q;
   assign digit_mask = mask_q;

endmodule

// File: tb/tb_seg7_word_capture.sv
// Directed bench for seg7_word_capture: scans encoded words through the multiplexed
// interface and checks captured words, pulses and the frame mask.
module tb_seg7_word_capture;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [6:0]  seg_in;
   logic [7:0]  dig_sel;
   logic [31:0] word_out;
   logic        word_valid;
   logic        err;
   logic [7:0]  digit_mask;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int err_cnt = 0;

   seg7_word_capture #(.STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .seg_in     (seg_in),
      .dig_sel    (dig_sel),
      .word_out   (word_out),
      .word_valid (word_valid),
      .err        (err),
      .digit_mask (digit_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_valid === 1'b1) valid_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
         4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
         4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
         4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
      endcase
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_digit(input int idx, input logic [6:0] pat, input int dwell);
      seg_in  = pat;
      dig_sel = 8'h01 << idx;
      cyc(dwell);
   endtask

   task automatic blank(input int n);
      seg_in  = 7'h7F;
      dig_sel = 8'h00;
      cyc(n);
   endtask

   task automatic scan_word(input logic [31:0] w, input int dwell);
      for (int i = 0; i < 8; i++) drive_digit(i, enc(w[4*i +: 4]), dwell);
      blank(3);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b0; seg_in = 7'h7F; dig_sel = 8'h00;
      #3;
      checks++; if (word_out !== 32'h0) begin errors++; $display("FAIL reset_word got %h want 00000000", word_out); end
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", word_valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", digit_mask); end
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      en = 1'b1;
      cyc(2);
   endtask

   task automatic test_full_scan;
      valid_cnt = 0; err_cnt = 0;
      scan_word(32'h1234ABCD, 6);
      checks++; if (valid_cnt != 1) begin errors++; $display("FAIL scan_valid_pulses got %0d want 1", valid_cnt); end
      checks++; if (word_out !== 32'h1234ABCD) begin errors++; $display("FAIL scan_word got %h want 1234abcd", word_out); end
      checks++; if (err_cnt != 0) begin errors++; $display("FAIL scan_err_pulses got %0d want 0", err_cnt); end
      checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL scan_mask_after got %h want 00", digit_mask); end
   endtask

   task automatic test_short_dwell;
      logic [31:0] w;
      w = 32'h89ABCDEF;
      valid_cnt = 0; err_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive_digit(i, enc(w[4*i +: 4]), 4);
         checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL short_mask digit %0d got %h want 00", i, digit_mask); end
      end
      blank(3);
      checks++; if (valid_cnt != 0) begin errors++; $display("FAIL short_valid got %0d want 0", valid_cnt); end
      checks++; if (word_out !== 32'h1234ABCD) begin errors++; $display("FAIL short_word got %h want 1234abcd", word_out); end
   endtask

   task automatic test_bad_glyph;
      valid_cnt = 0; err_cnt = 0;
      drive_digit(0, enc(4'h9), 6);
      drive_digit(1, enc(4'h8), 6);
      drive_digit(2, enc(4'h5), 6);
      checks++; if (digit_mask !== 8'h07) begin errors++; $display("FAIL bad_mask_pre got %h want 07", digit_mask); end
      drive_digit(3, 7'h7F, 6);
      blank(2);
      checks++; if (err_cnt != 1) begin errors++; $display("FAIL bad_err_pulses got %0d want 1", err_cnt); end
      checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL bad_mask_post got %h want 00", digit_mask); end
      checks++; if (word_out !== 32'h1234ABCD) begin errors++; $display("FAIL bad_word_kept got %h want 1234abcd", word_out); end
      checks++; if (valid_cnt != 0) begin errors++; $display("FAIL bad_valid got %0d want 0", valid_cnt); end
      scan_word(32'hCAFE0589, 6);
      checks++; if (word_out !== 32'hCAFE0589) begin errors++; $display("FAIL rescan_word got %h want cafe0589", word_out); end
      checks++; if (valid_cnt != 1) begin errors++; $display("FAIL rescan_valid got %0d want 1", valid_cnt); end
      checks++; if (err_cnt != 1) begin errors++; $display("FAIL rescan_err got %0d want 1", err_cnt); end
   endtask

   task automatic test_multi_sel;
      valid_cnt = 0; err_cnt = 0;
      drive_digit(0, enc(4'h2), 6);
      drive_digit(1, enc(4'h7), 6);
      checks++; if (digit_mask !== 8'h03) begin errors++; $display("FAIL multi_mask_pre got %h want 03", digit_mask); end
      seg_in = enc(4'h8); dig_sel = 8'h03;
      cyc(10);
      checks++; if (digit_mask !== 8'h03) begin errors++; $display("FAIL multi_mask_post got %h want 03", digit_mask); end
      checks++; if (err_cnt != 0) begin errors++; $display("FAIL multi_err got %0d want 0", err_cnt); end
      checks++; if (valid_cnt != 0) begin errors++; $display("FAIL multi_valid got %0d want 0", valid_cnt); end
      blank(1);
      en = 1'b0;
      cyc(2);
      checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL en_off_mask got %h want 00", digit_mask); end
      checks++; if (word_out !== 32'hCAFE0589) begin errors++; $display("FAIL en_off_word got %h want cafe0589", word_out); end
      en = 1'b1;
      cyc(2);
   endtask

   task automatic test_reset_midscan;
      logic [31:0] w;
      w = 32'h13579BDF;
      valid_cnt = 0; err_cnt = 0;
      for (int i = 0; i < 5; i++) drive_digit(i, enc(w[4*i +: 4]), 6);
      checks++; if (digit_mask !== 8'h1F) begin errors++; $display("FAIL mid_mask_pre got %h want 1f", digit_mask); end
      rst_n = 1'b0;
      #2;
      checks++; if (word_out !== 32'h0) begin errors++; $display("FAIL mid_reset_word got %h want 00000000", word_out); end
      checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL mid_reset_mask got %h want 00", digit_mask); end
      checks++; if (word_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses got %b%b want 00", word_valid, err); end
      cyc(1);
      rst_n = 1'b1;
      blank(1);
      scan_word(32'hDEADBEEF, 6);
      checks++; if (word_out !== 32'hDEADBEEF) begin errors++; $display("FAIL post_reset_word got %h want deadbeef", word_out); end
      checks++; if (valid_cnt != 1) begin errors++; $display("FAIL post_reset_valid got %0d want 1", valid_cnt); end
   endtask

   task automatic test_overwrite;
      valid_cnt = 0; err_cnt = 0;
      drive_digit(0, enc(4'h0), 6);
      drive_digit(1, enc(4'h1), 6);
      drive_digit(2, enc(4'h5), 6);
      checks++; if (digit_mask !== 8'h07) begin errors++; $display("FAIL ovr_mask_first got %h want 07", digit_mask); end
      drive_digit(2, enc(4'hA), 6);
      checks++; if (digit_mask !== 8'h07) begin errors++; $display("FAIL ovr_mask_second got %h want 07", digit_mask); end
      drive_digit(3, enc(4'h3), 6);
      drive_digit(4, enc(4'h4), 6);
      drive_digit(5, enc(4'h5), 6);
      drive_digit(6, enc(4'h6), 6);
      drive_digit(7, enc(4'h7), 6);
      blank(3);
      checks++; if (word_out !== 32'h76543A10) begin errors++; $display("FAIL ovr_word got %h want 76543a10", word_out); end
      checks++; if (valid_cnt != 1) begin errors++; $display("FAIL ovr_valid got %0d want 1", valid_cnt); end
      checks++; if (err_cnt != 0) begin errors++; $display("FAIL ovr_err got %0d want 0", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_short_dwell();
      test_bad_glyph();
      test_multi_sel();
      test_reset_midscan();
      test_overwrite();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule
